bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly downstream of the sequential multiplier: it takes the 16-bit product and that block's done level, and produces packed decimal digits for the display/readout stage. It starts on the rising edge of the upstream done, so a done level held high converts only once.

Parameters:
WIDTH, 16, binary input width in bits.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clk  input  1  clock; all state updates on posedge.
clearBar  input  1  asynchronous active-low reset.
bin_in  input  WIDTH  binary value to convert (upstream product); sampled only on the load edge.
src_done  input  1  upstream done level; its rising edge triggers a conversion.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
busy  output  1  high while a conversion is in progress.
done  output  1  high from conversion completion until the next load.
neg  output  1  sign of the converted value; constant 0 unless SIGNED_EN is defined.

Behaviour:
- Reset (clearBar=0, asynchronous, any state): bcd_out=0, busy=0, done=0, neg=0, state=IDLE, internal shift/BCD registers=0, src_done history register=0. Takes effect immediately, including mid-conversion; the partial result is discarded.
- Edge detect: a registered copy of src_done updates every clock. trig = src_done & ~src_done_q.
- States: IDLE, SHIFT.
- IDLE:
  - On a clock where trig=1: capture bin_in into the shift register, clear the BCD scratch register, load the bit counter with WIDTH, set busy=1 and done=0, go to SHIFT.
  - Otherwise hold; bcd_out and done keep their previous values.
- SHIFT, one bit per clock:
  - For each digit of the scratch register, add 3 if the digit is >=5.
  - Then shift {scratch, shift register} left by 1; the MSB of the shift register enters bit 0 of the scratch register.
  - Decrement the bit counter.
  - On the clock that performs the WIDTH-th shift: write the scratch result to bcd_out, set done=1 and busy=0, return to IDLE.
- Latency: done rises at the WIDTH-th clock edge after the load edge (16 cycles at default). bcd_out changes only on that edge.
- trig while in SHIFT: ignored and not queued. The edge is consumed, so a src_done that stays high afterwards does not retrigger.
- trig on the same edge that conversion completes: ignored; the converter is still in SHIFT on that edge.
- bin_in changes after the load edge have no effect on the conversion in progress.
- Arithmetic: adds are performed per 4-bit digit with no carry between digits. Digits never exceed 9 after the final shift, given the DIGITS constraint.
- Back-to-back operation: a new trig in IDLE with done=1 clears done on the load edge and starts a new conversion. bcd_out holds the old result until the new one completes.

Optional Feature:
SIGNED_EN
- Defined:
  - bin_in is two's complement.
  - On the load edge, the shift register gets |bin_in| (computed as WIDTH-bit unsigned negate when the MSB is 1) and a sign flag is captured.
  - neg is updated together with bcd_out on completion; it is cleared on reset.
  - Most-negative input -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), which must convert correctly.
- Not defined: bin_in is unsigned, no sign logic is synthesised, neg is tied 0.

Test Plan:
- Reset, then no trigger for 20 cycles -> bcd_out=0x00000, busy=0, done=0, neg=0.
- bin_in=16'd12345, src_done 0->1 -> busy=1 from the next cycle; done=1 exactly 16 edges after the load edge; bcd_out=20'h12345; src_done held high 40 more cycles -> no further busy.
- bin_in=0 -> bcd_out=20'h00000. bin_in=16'hFFFF -> bcd_out=20'h65535 (unsigned build).
- Load bin_in=255. After 8 cycles, pulse src_done low then high again -> re-trigger ignored. Result 20'h00255 at the normal time. A later trigger with bin_in=9 clears done on the load edge and gives 20'h00009.
- Load 16'd999, assert clearBar=0 after 5 cycles -> all outputs 0 immediately. Release reset, trigger with 16'd42 -> 20'h00042 after 16 cycles.
- SIGNED_EN defined:
  - bin_in=16'hFFFF -> neg=1, bcd_out=20'h00001.
  - bin_in=16'h8000 -> neg=1, bcd_out=20'h32768.
  - bin_in=16'd100 -> neg=0, bcd_out=20'h00100.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter (double dabble, one bit per clock); optional signed input via SIGNED_EN
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  clearBar,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  src_done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  neg
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int         CW    = $clog2(WIDTH + 1);

  logic [0:0]          state;
  logic                src_done_q;
  logic                trig;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nxt;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    load_val;

  assign trig = src_done & ~src_done_q;

`ifdef SIGNED_EN
  logic sign_q;
  logic neg_q;

  // Two's-complement magnitude; the most-negative value maps onto itself, which is the correct unsigned magnitude
  assign load_val = bin_in[WIDTH-1] ? (~bin_in + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_in;
  assign neg      = neg_q;

  // Capture the sign at load and publish it alongside the digits at completion
  always_ff @(posedge clk or negedge clearBar) begin
    if (!clearBar) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state == IDLE && trig) begin
      sign_q <= bin_in[WIDTH-1];
    end else if (state == SHIFT && cnt == CW'(1)) begin
      neg_q  <= sign_q;
    end
  end
`else
  assign load_val = bin_in;
  assign neg      = 1'b0;
`endif

  // Per-digit add-3 correction, no carry between digits, then the one-bit shift into the scratch
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_nxt = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
  end

  // Registered copy of the upstream done level for rising-edge detection
  always_ff @(posedge clk or negedge clearBar) begin
    if (!clearBar) begin
      src_done_q <= 1'b0;
    end else begin
      src_done_q <= src_done;
    end
  end

  // Control FSM and datapath: load on trigger in IDLE, shift WIDTH times, then publish
  always_ff @(posedge clk or negedge clearBar) begin
    if (!clearBar) begin
      state   <= IDLE;
      sh      <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            sh      <= load_val;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          sh      <= {sh[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= scratch_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed-vector bench for bin2bcd_seq (expectations follow SIGNED_EN when defined)
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        clearBar = 1'b0;
  logic [15:0] bin_in = '0;
  logic        src_done = 1'b0;
  logic [19:0] bcd_out;
  logic        busy;
  logic        done;
  logic        neg;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .clearBar(clearBar), .bin_in(bin_in), .src_done(src_done),
    .bcd_out(bcd_out), .busy(busy), .done(done), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise src_done, count edges from the load edge until done; optionally pulse src_done mid-run
  task automatic convert(input logic [15:0] v, input bit pulse, output int edges,
                         output logic busy1, output logic done1);
    @(negedge clk);
    bin_in   = v;
    src_done = 1'b1;
    @(posedge clk);
    edges = 0;
    busy1 = 1'b0;
    done1 = 1'b1;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        busy1 = busy;
        done1 = done;
      end
      if (edges == 2) bin_in = ~v;
      if (pulse && edges == 8) src_done = 1'b0;
      if (pulse && edges == 9) src_done = 1'b1;
      if (done) break;
    end
  endtask

  task automatic release_src();
    @(negedge clk);
    src_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd,
                     input logic exp_neg);
    int   e;
    logic b1, d1;
    convert(v, 1'b0, e, b1, d1);
    check({tag, "_busy1"}, 32'(b1), 32'd1);
    check({tag, "_lat"}, 32'(e), 32'd16);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    release_src();
  endtask

  initial begin
    int   e;
    logic b1, d1;
    int   busy_seen;

    // reset and idle
    repeat (3) @(negedge clk);
    clearBar = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);

    // 12345 with src_done held high afterwards
    convert(16'd12345, 1'b0, e, b1, d1);
    check("c12345_busy1", 32'(b1), 32'd1);
    check("c12345_done1", 32'(d1), 32'd0);
    check("c12345_lat", 32'(e), 32'd16);
    check("c12345_bcd", 32'(bcd_out), 32'h12345);
    check("c12345_neg", 32'(neg), 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("held_high_busy", 32'(busy_seen), 32'd0);
    check("held_high_done", 32'(done), 32'd1);
    release_src();

    run("zero", 16'd0, 20'h00000, 1'b0);
`ifdef SIGNED_EN
    run("ffff", 16'hFFFF, 20'h00001, 1'b1);
    run("min", 16'h8000, 20'h32768, 1'b1);
    run("c100", 16'd100, 20'h00100, 1'b0);
`else
    run("ffff", 16'hFFFF, 20'h65535, 1'b0);
    run("c8000", 16'h8000, 20'h32768, 1'b0);
`endif

    // re-trigger during SHIFT is ignored
    convert(16'd255, 1'b1, e, b1, d1);
    check("c255_lat", 32'(e), 32'd16);
    check("c255_bcd", 32'(bcd_out), 32'h00255);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("c255_no_requeue", 32'(busy_seen), 32'd0);
    release_src();

    // back-to-back: done clears on the load edge, old result held meanwhile
    convert(16'd9, 1'b0, e, b1, d1);
    check("c9_done1", 32'(d1), 32'd0);
    check("c9_lat", 32'(e), 32'd16);
    check("c9_bcd", 32'(bcd_out), 32'h00009);
    release_src();

    // mid-conversion asynchronous reset
    @(negedge clk);
    bin_in   = 16'd999;
    src_done = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    clearBar = 1'b0;
    #1;
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_neg", 32'(neg), 32'd0);
    @(negedge clk);
    src_done = 1'b0;
    @(negedge clk);
    clearBar = 1'b1;
    @(negedge clk);
    run("c42", 16'd42, 20'h00042, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
